// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_scan_ctrl: multiplexed digit scan sequencer with per-frame shadowing |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module digit_scan_ctrl #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16,
  parameter int CNT_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [2:0]  i_last,
  input  logic [31:0] i_data,
  output logic [2:0]  o_sel,
  output logic [3:0]  o_nibble,
  output logic        o_blank,
  output logic        o_frame
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SHOW      = 2'd1,
    S_BLANK_GAP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_dwell_end = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_shadow;
  logic [2:0]       r_last;

  logic [2:0]       w_sel_inc;
  logic [3:0]       w_nib_next;

  assign w_sel_inc  = o_sel + 3'd1;
  assign w_nib_next = r_shadow[{w_sel_inc, 2'b00} +: 4];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_last   <= '0;
      o_sel    <= '0;
      o_nibble <= '0;
      o_blank  <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      o_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          o_sel   <= '0;
          o_blank <= 1'b1;
          if (i_en) begin
            r_shadow <= i_data;
            r_last   <= i_last;
            o_nibble <= i_data[3:0];
            o_blank  <= 1'b0;
            r_state  <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_cnt == c_dwell_end) begin
            r_cnt   <= '0;
            o_blank <= 1'b1;
            r_state <= S_BLANK_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BLANK_GAP: begin
          if (r_cnt == c_blank_end) begin
            r_cnt <= '0;
            if (o_sel != r_last) begin
              o_sel    <= w_sel_inc;
              o_nibble <= w_nib_next;
              o_blank  <= 1'b0;
              r_state  <= S_SHOW;
            end else begin
              // Frame boundary: the only point where new data/length is accepted
              o_frame <= 1'b1;
              o_sel   <= '0;
              if (i_en) begin
                r_shadow <= i_data;
                r_last   <= i_last;
                o_nibble <= i_data[3:0];
                o_blank  <= 1'b0;
                r_state  <= S_SHOW;
              end else begin
                o_nibble <= r_shadow[3:0];
                r_state  <= S_IDLE;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_digit_scan_ctrl: self-checking bench for digit_scan_ctrl (DWELL=4, B=2) |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_digit_scan_ctrl;

  localparam int c_dwell = 4;
  localparam int c_blank = 2;
  localparam int c_pd    = c_dwell + c_blank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  last = 3'd0;
  logic [31:0] data = 32'h0;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  digit_scan_ctrl #(.DWELL(c_dwell), .BLANK(c_blank), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_last  (last),
    .i_data  (data),
    .o_sel   (sel),
    .o_nibble(nibble),
    .o_blank (blank),
    .o_frame (frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: position within the current frame; outputs follow from arithmetic on it.
  bit          m_active = 1'b0;
  int          m_p      = 0;
  logic [31:0] m_shadow = '0;
  int          m_last   = 0;
  bit          m_frame  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_p = 0; m_shadow = '0; m_last = 0; m_frame = 1'b0;
    end else if (!m_active) begin
      m_frame = 1'b0;
      if (en) begin
        m_active = 1'b1; m_p = 0; m_shadow = data; m_last = int'(last);
      end
    end else if (m_p == (m_last + 1) * c_pd - 1) begin
      m_frame = 1'b1;
      if (en) begin
        m_p = 0; m_shadow = data; m_last = int'(last);
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_p++;
      m_frame = 1'b0;
    end
  end

  int   e_sel;
  logic e_blank;
  logic [3:0] e_nib;
  always_comb begin
    e_sel   = m_active ? m_p / c_pd : 0;
    e_blank = !m_active || ((m_p % c_pd) >= c_dwell);
    e_nib   = m_shadow[e_sel*4 +: 4];
  end

  always @(negedge clk) begin
    chk("sel", 32'(sel), 32'(e_sel));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("frame", 32'(frame), 32'(m_frame));
    if (!rst_n) chk("nibble_rst", 32'(nibble), 32'h0);
    else if (!e_blank) chk("nibble", 32'(nibble), 32'(e_nib));
  end

  task automatic wait_frame(output int at);
    bit ok = 1'b0;
    at = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame) begin ok = 1'b1; at = cyc; break; end
    end
    chk("frame_timeout", 32'(ok), 32'h1);
  endtask

  task automatic wait_sel(input logic [2:0] s);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel == s && !blank) begin ok = 1'b1; break; end
    end
    chk("sel_timeout", 32'(ok), 32'h1);
  endtask

  int t1, t2, t3, t4;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_blank", 32'(blank), 32'h1);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_nib", 32'(nibble), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);

    // Full scan
    rst_n = 1'b1; en = 1'b1; last = 3'd7; data = 32'h76543210;
    @(posedge clk); #1;
    chk("start_blank", 32'(blank), 32'h0);
    chk("start_sel", 32'(sel), 32'h0);
    chk("start_nib", 32'(nibble), 32'h0);
    wait_frame(t1);
    wait_frame(t2);
    chk("period_48", 32'(t2 - t1), 32'd48);

    // Shadow: change data mid-frame
    wait_sel(3'd3);
    data = 32'hFFFFFFFF;
    wait_sel(3'd5);
    chk("shadow_nib5", 32'(nibble), 32'h5);
    wait_frame(t1);
    chk("new_frame_nib", 32'(nibble), 32'hF);
    chk("new_frame_sel", 32'(sel), 32'h0);

    // Short frame, with i_last changes deferred to frame boundaries
    wait_sel(3'd1);
    last = 3'd2; data = 32'h76543210;
    wait_sel(3'd5);
    chk("last_deferred", 32'(sel), 32'h5);
    wait_frame(t1);
    wait_frame(t2);
    chk("period_18", 32'(t2 - t1), 32'd18);
    wait_sel(3'd1);
    last = 3'd5;
    wait_frame(t3);
    chk("period_18_b", 32'(t3 - t2), 32'd18);
    wait_frame(t4);
    chk("period_36", 32'(t4 - t3), 32'd36);

    // Enable drop mid-frame
    last = 3'd7;
    wait_frame(t1);
    wait_sel(3'd4);
    en = 1'b0;
    wait_sel(3'd7);
    chk("drop_sel7", 32'(nibble), 32'h7);
    wait_frame(t2);
    chk("drop_period", 32'(t2 - t1), 32'd48);
    chk("idle_blank", 32'(blank), 32'h1);
    chk("idle_sel", 32'(sel), 32'h0);
    repeat (10) @(negedge clk);
    chk("idle_hold", 32'(blank), 32'h1);

    // Reset mid-operation
    en = 1'b1;
    wait_sel(3'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_blank", 32'(blank), 32'h1);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_nib", 32'(nibble), 32'h0);
    chk("async_frame", 32'(frame), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_sel", 32'(sel), 32'h0);
    chk("restart_blank", 32'(blank), 32'h0);
    wait_frame(t1);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
